// File: rtl/inference_engine_if.sv
// inference_engine_if: start/done handshake plus RAM A/B/C read ports and the
// RES write port of the inference engine.
//   master : the engine (drives Busy/Done, read requests, result writes)
//   slave  : the surrounding RAMs and coprocessor control
interface inference_engine_if #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned A_DEPTH_BITS   = 9,
    parameter int unsigned B_DEPTH_BITS   = 4,
    parameter int unsigned C_DEPTH_BITS   = 2,
    parameter int unsigned RES_DEPTH_BITS = 6
);
    logic                      Start;
    logic                      Busy;
    logic                      Done;

    logic                      A_read_en;
    logic [A_DEPTH_BITS-1:0]   A_read_address;
    logic [WIDTH-1:0]          A_read_data_out;

    logic                      B_read_en;
    logic [B_DEPTH_BITS-1:0]   B_read_address;
    logic [WIDTH-1:0]          B_read_data_out;

    logic                      C_read_en;
    logic [C_DEPTH_BITS-1:0]   C_read_address;
    logic [WIDTH-1:0]          C_read_data_out;

    logic                      RES_write_en;
    logic [RES_DEPTH_BITS-1:0] RES_write_address;
    logic [WIDTH-1:0]          RES_write_data_in;

    modport master (
        input  Start,
        output Busy, Done,
        output A_read_en, A_read_address, input A_read_data_out,
        output B_read_en, B_read_address, input B_read_data_out,
        output C_read_en, C_read_address, input C_read_data_out,
        output RES_write_en, RES_write_address, RES_write_data_in
    );

    modport slave (
        output Start,
        input  Busy, Done,
        input  A_read_en, A_read_address, output A_read_data_out,
        input  B_read_en, B_read_address, output B_read_data_out,
        input  C_read_en, C_read_address, output C_read_data_out,
        input  RES_write_en, RES_write_address, RES_write_data_in
    );
endinterface

// File: rtl/inference_engine.sv
// inference_engine: single-MAC one-hidden-layer perceptron over N_POINTS points.
// Features come from RAM A, hidden weights from RAM B (row 0 = bias), output
// weights from RAM C (word 0 = bias); one result per point goes to RAM RES.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high
//   bus   - inference_engine_if.master (Start/Busy/Done, A/B/C reads, RES write)
// Build option: define INFERENCE_SATURATE_EN to clamp node values to 2^WIDTH-1
// instead of keeping the low WIDTH bits.
module inference_engine #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned N_FEATURES     = 7,
    parameter int unsigned N_HIDDEN       = 2,
    parameter int unsigned N_POINTS       = 64,
    parameter int unsigned FRAC_BITS      = 8,
    parameter int unsigned A_DEPTH_BITS   = 9,
    parameter int unsigned B_DEPTH_BITS   = 4,
    parameter int unsigned C_DEPTH_BITS   = 2,
    parameter int unsigned RES_DEPTH_BITS = 6
) (
    input  logic               clk,
    input  logic               reset,
    inference_engine_if.master bus
);
    localparam int unsigned MAX_NK = (N_FEATURES > N_HIDDEN) ? N_FEATURES : N_HIDDEN;
    localparam int unsigned ACC_W  = WIDTH + $clog2(MAX_NK + 1) + 1;
    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned K_W    = $clog2(MAX_NK + 1);
    localparam int unsigned H_W    = (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1;
    localparam int unsigned I_W    = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_HID_ISSUE, S_HID_DRAIN, S_HID_STORE,
        S_OUT_ISSUE, S_OUT_DRAIN, S_WRITE, S_DONE
    } state_e;

    state_e                    state_q, state_d;
    logic [K_W-1:0]            k_q, k_d;
    logic [H_W-1:0]            h_q, h_d;
    logic [I_W-1:0]            i_q, i_d;
    logic [ACC_W-1:0]          acc_q, acc_d;
    logic [WIDTH-1:0]          hidden_q [N_HIDDEN];
    logic [WIDTH-1:0]          hidden_d [N_HIDDEN];

    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      a_en_q, a_en_d;
    logic [A_DEPTH_BITS-1:0]   a_addr_q, a_addr_d;
    logic                      b_en_q, b_en_d;
    logic [B_DEPTH_BITS-1:0]   b_addr_q, b_addr_d;
    logic                      c_en_q, c_en_d;
    logic [C_DEPTH_BITS-1:0]   c_addr_q, c_addr_d;
    logic                      res_en_q, res_en_d;
    logic [RES_DEPTH_BITS-1:0] res_addr_q, res_addr_d;
    logic [WIDTH-1:0]          res_data_q, res_data_d;

    // Collapse a node sum to WIDTH bits (clamp or wrap depending on build).
    function automatic logic [WIDTH-1:0] reduce(input logic [ACC_W-1:0] v);
`ifdef INFERENCE_SATURATE_EN
        return (|v[ACC_W-1:WIDTH]) ? {WIDTH{1'b1}} : v[WIDTH-1:0];
`else
        return WIDTH'(v);
`endif
    endfunction

    // One scaled product term: full 2*WIDTH product, then drop FRAC_BITS.
    function automatic logic [ACC_W-1:0] term(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] w);
        logic [PROD_W-1:0] p;
        p = PROD_W'(x) * PROD_W'(w);
        return ACC_W'(p >> FRAC_BITS);
    endfunction

    // Next state and datapath; read data always belongs to the previous cycle's issue.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        h_d      = h_q;
        i_d      = i_q;
        acc_d    = acc_q;
        hidden_d = hidden_q;

        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    state_d = S_HID_ISSUE;
                    k_d     = '0;
                    h_d     = '0;
                    i_d     = '0;
                    acc_d   = '0;
                end
            end
            S_HID_ISSUE: begin
                // k=1 receives the bias issued at k=0; later cycles receive products
                if (k_q == K_W'(1)) begin
                    acc_d = acc_q + ACC_W'(bus.B_read_data_out);
                end else if (k_q != '0) begin
                    acc_d = acc_q + term(bus.A_read_data_out, bus.B_read_data_out);
                end
                if (k_q == K_W'(N_FEATURES)) begin
                    state_d = S_HID_DRAIN;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            S_HID_DRAIN: begin
                acc_d   = acc_q + term(bus.A_read_data_out, bus.B_read_data_out);
                state_d = S_HID_STORE;
            end
            S_HID_STORE: begin
                hidden_d[h_q] = reduce(acc_q);
                acc_d         = '0;
                k_d           = '0;
                if (h_q == H_W'(N_HIDDEN - 1)) begin
                    state_d = S_OUT_ISSUE;
                end else begin
                    h_d     = h_q + H_W'(1);
                    state_d = S_HID_ISSUE;
                end
            end
            S_OUT_ISSUE: begin
                // data arriving at k pairs C[k-1] with hidden[k-2]
                if (k_q == K_W'(1)) begin
                    acc_d = acc_q + ACC_W'(bus.C_read_data_out);
                end else if (k_q != '0) begin
                    acc_d = acc_q + term(hidden_q[H_W'(k_q - K_W'(2))], bus.C_read_data_out);
                end
                if (k_q == K_W'(N_HIDDEN)) begin
                    state_d = S_OUT_DRAIN;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            S_OUT_DRAIN: begin
                acc_d   = acc_q + term(hidden_q[H_W'(N_HIDDEN - 1)], bus.C_read_data_out);
                state_d = S_WRITE;
            end
            S_WRITE: begin
                acc_d = '0;
                k_d   = '0;
                h_d   = '0;
                if (i_q == I_W'(N_POINTS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    i_d     = i_q + I_W'(1);
                    state_d = S_HID_ISSUE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered outputs are decoded from the next state so they line up with it.
    always_comb begin
        busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        a_en_d     = (state_d == S_HID_ISSUE) && (k_d != '0);
        a_addr_d   = '0;
        b_en_d     = (state_d == S_HID_ISSUE);
        b_addr_d   = '0;
        c_en_d     = (state_d == S_OUT_ISSUE);
        c_addr_d   = '0;
        res_en_d   = (state_d == S_WRITE);
        res_addr_d = '0;
        res_data_d = '0;

        if (a_en_d) begin
            a_addr_d = A_DEPTH_BITS'(32'(i_d) * N_FEATURES + 32'(k_d) - 32'd1);
        end
        if (b_en_d) begin
            b_addr_d = B_DEPTH_BITS'(32'(k_d) * N_HIDDEN + 32'(h_d));
        end
        if (c_en_d) begin
            c_addr_d = C_DEPTH_BITS'(k_d);
        end
        if (res_en_d) begin
            res_addr_d = RES_DEPTH_BITS'(i_d);
            res_data_d = reduce(acc_d);
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            h_q        <= '0;
            i_q        <= '0;
            acc_q      <= '0;
            for (int n = 0; n < int'(N_HIDDEN); n++) begin
                hidden_q[n] <= '0;
            end
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            a_en_q     <= 1'b0;
            a_addr_q   <= '0;
            b_en_q     <= 1'b0;
            b_addr_q   <= '0;
            c_en_q     <= 1'b0;
            c_addr_q   <= '0;
            res_en_q   <= 1'b0;
            res_addr_q <= '0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            h_q        <= h_d;
            i_q        <= i_d;
            acc_q      <= acc_d;
            hidden_q   <= hidden_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            a_en_q     <= a_en_d;
            a_addr_q   <= a_addr_d;
            b_en_q     <= b_en_d;
            b_addr_q   <= b_addr_d;
            c_en_q     <= c_en_d;
            c_addr_q   <= c_addr_d;
            res_en_q   <= res_en_d;
            res_addr_q <= res_addr_d;
            res_data_q <= res_data_d;
        end
    end

    assign bus.Busy              = busy_q;
    assign bus.Done              = done_q;
    assign bus.A_read_en         = a_en_q;
    assign bus.A_read_address    = a_addr_q;
    assign bus.B_read_en         = b_en_q;
    assign bus.B_read_address    = b_addr_q;
    assign bus.C_read_en         = c_en_q;
    assign bus.C_read_address    = c_addr_q;
    assign bus.RES_write_en      = res_en_q;
    assign bus.RES_write_address = res_addr_q;
    assign bus.RES_write_data_in = res_data_q;
endmodule

// File: tb/tb_inference_engine.sv
// Testbench for inference_engine: a default-parameter instance and a small
// (2 features, 2 hidden, 1 point) instance share clk/reset. Expected writes
// and Done pulses are queued at Start; a negedge monitor pops and compares.
module tb_inference_engine;
    localparam int FB  = 8;
    localparam int NF  = 7;
    localparam int NH  = 2;
    localparam int NP  = 64;
    localparam int P   = NH * (NF + 3) + NH + 3;
    localparam int SNF = 2;
    localparam int SNH = 2;
    localparam int SP  = SNH * (SNF + 3) + SNH + 3;

    typedef struct { int addr; int data; longint cyc; } wr_t;

    logic   clk = 1'b0;
    logic   reset;
    longint cyc = 0;
    int     n_cmp = 0;
    int     n_bad = 0;

    int unsigned ba[$], bb[$], bc[$], sa[$], sb[$], sc[$];
    wr_t         big_q[$], sm_q[$];
    longint      big_done_q[$], sm_done_q[$];
    wr_t         eb, es;
    longint      db, ds;

    inference_engine_if big_if ();
    inference_engine_if #(.A_DEPTH_BITS(2), .B_DEPTH_BITS(3), .C_DEPTH_BITS(2),
                          .RES_DEPTH_BITS(1)) sm_if ();

    inference_engine u_big (.clk(clk), .reset(reset), .bus(big_if));
    inference_engine #(.N_FEATURES(SNF), .N_HIDDEN(SNH), .N_POINTS(1),
                       .A_DEPTH_BITS(2), .B_DEPTH_BITS(3), .C_DEPTH_BITS(2),
                       .RES_DEPTH_BITS(1)) u_small (.clk(clk), .reset(reset), .bus(sm_if));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM models with one cycle of read latency
    always @(posedge clk) begin
        if (big_if.A_read_en) big_if.A_read_data_out <= 8'(ba[big_if.A_read_address]);
        if (big_if.B_read_en) big_if.B_read_data_out <= 8'(bb[big_if.B_read_address]);
        if (big_if.C_read_en) big_if.C_read_data_out <= 8'(bc[big_if.C_read_address]);
        if (sm_if.A_read_en)  sm_if.A_read_data_out  <= 8'(sa[sm_if.A_read_address]);
        if (sm_if.B_read_en)  sm_if.B_read_data_out  <= 8'(sb[sm_if.B_read_address]);
        if (sm_if.C_read_en)  sm_if.C_read_data_out  <= 8'(sc[sm_if.C_read_address]);
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input longint act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got event at cycle %0d, expected none", name, act);
    endtask

    // Reference model: node value reduced to 8 bits
    function automatic int unsigned red(input int unsigned v);
`ifdef INFERENCE_SATURATE_EN
        return (v > 255) ? 255 : v;
`else
        return v % 256;
`endif
    endfunction

    function automatic int unsigned ref_point(input int nf, input int nh, input int i,
                                              input int unsigned a[$], input int unsigned b[$],
                                              input int unsigned c[$]);
        int unsigned hid[$];
        int unsigned acc;
        for (int h = 0; h < nh; h++) begin
            acc = b[h];
            for (int j = 0; j < nf; j++) acc += (a[i * nf + j] * b[(j + 1) * nh + h]) >> FB;
            hid.push_back(red(acc));
        end
        acc = c[0];
        for (int h = 0; h < nh; h++) acc += (hid[h] * c[h + 1]) >> FB;
        return red(acc);
    endfunction

    function automatic int pending();
        return big_q.size() + big_done_q.size() + sm_q.size() + sm_done_q.size();
    endfunction

    function automatic longint big_outs();
        return longint'({big_if.Busy, big_if.Done, big_if.A_read_en, big_if.A_read_address,
                         big_if.B_read_en, big_if.B_read_address, big_if.C_read_en,
                         big_if.C_read_address, big_if.RES_write_en,
                         big_if.RES_write_address, big_if.RES_write_data_in});
    endfunction

    function automatic longint sm_outs();
        return longint'({sm_if.Busy, sm_if.Done, sm_if.A_read_en, sm_if.A_read_address,
                         sm_if.B_read_en, sm_if.B_read_address, sm_if.C_read_en,
                         sm_if.C_read_address, sm_if.RES_write_en,
                         sm_if.RES_write_address, sm_if.RES_write_data_in});
    endfunction

    // Run starting with Start high during cycle s: write i at s+(i+1)*P, Done at s+NP*P+1
    task automatic plan_big(input longint s, input int npts, input bit with_done);
        wr_t e;
        for (int i = 0; i < npts; i++) begin
            e.addr = i;
            e.data = int'(ref_point(NF, NH, i, ba, bb, bc));
            e.cyc  = s + longint'((i + 1) * P);
            big_q.push_back(e);
        end
        if (with_done) big_done_q.push_back(s + longint'(NP * P + 1));
    endtask

    task automatic load_big();
        ba.delete(); bb.delete(); bc.delete();
        for (int x = 0; x < NP * NF; x++) ba.push_back($urandom_range(0, 255));
        for (int x = 0; x < (NF + 1) * NH; x++) bb.push_back($urandom_range(0, 255) >> $urandom_range(0, 2));
        for (int x = 0; x < NH + 1; x++) bc.push_back($urandom_range(0, 255));
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while (pending() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (pending() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: %0d events still pending, expected 0", name, pending());
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic run_small();
        wr_t    e;
        longint s;
        @(posedge clk); #1;
        sm_if.Start = 1'b1;
        s = cyc;
        e.addr = 0;
        e.data = int'(ref_point(SNF, SNH, 0, sa, sb, sc));
        e.cyc  = s + longint'(SP);
        sm_q.push_back(e);
        sm_done_q.push_back(s + longint'(SP + 1));
        @(posedge clk); #1;
        sm_if.Start = 1'b0;
        drain(100, "small run");
    endtask

    // Monitor: scoreboard pops plus per-cycle read discipline
    always @(negedge clk) begin
        if (!reset) begin
            if (big_if.RES_write_en) begin
                if (big_q.size() == 0) flag("big unexpected RES write", cyc);
                else begin
                    eb = big_q.pop_front();
                    check("big wr addr", longint'(big_if.RES_write_address), eb.addr);
                    check("big wr data", longint'(big_if.RES_write_data_in), eb.data);
                    check("big wr cycle", cyc, eb.cyc);
                    check("big busy at write", longint'(big_if.Busy), 1);
                end
            end
            if (big_if.Done) begin
                if (big_done_q.size() == 0) flag("big unexpected Done", cyc);
                else begin
                    db = big_done_q.pop_front();
                    check("big done cycle", cyc, db);
                    check("big busy in done", longint'(big_if.Busy), 0);
                end
            end
            if (big_if.B_read_en)
                check("big A_en vs B row", longint'(big_if.A_read_en),
                      longint'(big_if.B_read_address >= 4'(NH)));
            else if (big_if.A_read_en) flag("big A_en without B_en", cyc);

            if (sm_if.RES_write_en) begin
                if (sm_q.size() == 0) flag("small unexpected RES write", cyc);
                else begin
                    es = sm_q.pop_front();
                    check("small wr addr", longint'(sm_if.RES_write_address), es.addr);
                    check("small wr data", longint'(sm_if.RES_write_data_in), es.data);
                    check("small wr cycle", cyc, es.cyc);
                end
            end
            if (sm_if.Done) begin
                if (sm_done_q.size() == 0) flag("small unexpected Done", cyc);
                else begin
                    ds = sm_done_q.pop_front();
                    check("small done cycle", cyc, ds);
                    check("small busy in done", longint'(sm_if.Busy), 0);
                end
            end
            if (sm_if.B_read_en)
                check("small A_en vs B row", longint'(sm_if.A_read_en),
                      longint'(sm_if.B_read_address >= 3'(SNH)));
        end
    end

    initial begin
        longint s, s2, t;
        int     n;
        reset = 1'b1;
        big_if.Start = 1'b0;
        sm_if.Start  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("big outputs in reset", big_outs(), 0);
        check("small outputs in reset", sm_outs(), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // small: basic datapath, then overflow
        sa = {128, 128};
        sb = {10, 20, 64, 128, 64, 128};
        sc = {5, 128, 128};
        run_small();
        sa = {255, 255};
        sb = {250, 250, 255, 255, 255, 255};
        sc = {0, 255, 0};
        run_small();

        // full run with Start pulsed while busy
        load_big();
        @(posedge clk); #1;
        big_if.Start = 1'b1;
        s = cyc;
        plan_big(s, NP, 1'b1);
        n = 0;
        while (pending() != 0 && n < 3000) begin
            @(posedge clk); #1;
            big_if.Start = big_if.Busy && ($urandom_range(0, 5) == 0);
            n++;
        end
        big_if.Start = 1'b0;
        drain(10, "run with busy Start pulses");

        // Start held high: second run begins in the cycle after Done
        load_big();
        @(posedge clk); #1;
        big_if.Start = 1'b1;
        s  = cyc;
        s2 = s + longint'(NP * P + 2);
        plan_big(s, NP, 1'b1);
        plan_big(s2, NP, 1'b1);
        n = 0;
        while (pending() != 0 && n < 4000) begin
            @(posedge clk); #1;
            if (cyc >= s2 + 5) big_if.Start = 1'b0;
            n++;
        end
        big_if.Start = 1'b0;
        drain(10, "back-to-back runs");

        // reset during OUT_ISSUE of point 3
        load_big();
        @(posedge clk); #1;
        big_if.Start = 1'b1;
        s = cyc;
        plan_big(s, 3, 1'b0);
        @(posedge clk); #1;
        big_if.Start = 1'b0;
        t = s + longint'(3 * P + 22);
        while (cyc < t) begin
            @(posedge clk); #1;
        end
        check("big C_en before reset", longint'(big_if.C_read_en), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("big outputs after mid-run reset", big_outs(), 0);
        repeat (3 * P) @(posedge clk);
        check("big writes before abort", longint'(big_q.size()), 0);

        // fresh run after the abort, same data
        @(posedge clk); #1;
        big_if.Start = 1'b1;
        s = cyc;
        plan_big(s, NP, 1'b1);
        @(posedge clk); #1;
        big_if.Start = 1'b0;
        drain(2000, "run after reset");

        check("scoreboard drained", longint'(pending()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
